// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg : shared definitions for the instruction fetch unit.
//   fetch_state_t : request FSM states
//                   S_REQ  - a request may be issued
//                   S_WAIT - waiting for the word of the outstanding request
//                   S_DROP - waiting for a word that a redirect made stale
//   PC_INC        : PC step between sequential instructions
//   NOP_WORD      : value presented to IF/ID out of reset
//   word_align()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if : instruction memory read channel.
//   imem_req    : read request valid (fetch -> memory)
//   imem_addr   : word address, bits [1:0] always 0 (fetch -> memory)
//   imem_ready  : memory accepts a request when imem_req & imem_ready
//   imem_rvalid : one pulse per accepted request, latency >= 1 cycle
//   imem_rdata  : instruction word, valid with imem_rvalid
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_holding_buffer.sv
// ---------------------------------------------------------------------------
// fetch_holding_buffer : one-entry buffer between the memory response and
// the IF/ID register.
//   clk, reset : clock and synchronous active-high reset
//   i_load     : capture i_instr / i_pc4 and mark the entry valid
//   i_instr    : returned instruction word
//   i_pc4      : address of that word + 4
//   i_consume  : IF/ID takes the entry this edge
//   i_flush    : discard the entry (redirect)
//   o_valid    : entry holds a word not yet taken by IF/ID
//   o_instr    : buffered instruction word
//   o_pc4      : buffered PC + 4
// Flush wins over load, load wins over consume. The word/PC fields are
// kept when the entry is consumed or flushed; only o_valid drops.
// ---------------------------------------------------------------------------
module fetch_holding_buffer
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  input  logic        i_consume,
  input  logic        i_flush,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc4;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= NOP_WORD;
      r_pc4   <= 32'd0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;

endmodule

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit : fetch stage front end.
// Owns the PC, keeps at most one read outstanding on the instruction memory
// and holds the returned word until the IF/ID register takes it.
//   clk          : rising-edge clock
//   reset        : synchronous active-high reset
//   stall        : IF/ID must not accept a new instruction this cycle
//   redirect     : taken branch/jump this cycle
//   redirect_pc  : target PC, bits [1:0] ignored
//   imem         : instruction memory read channel (master side)
//   instruction  : word presented to IF/ID
//   PCplus4      : address of presented word + 4
//   IF_ID_Write  : 1 = IF/ID captures this edge, 0 = bubble
// Parameter RESET_PC : PC after reset (bits [1:0] forced to 0).
// ---------------------------------------------------------------------------
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             redirect,
  input  logic [31:0]                      redirect_pc,
  instruction_fetch_unit_if.master         imem,
  output logic [31:0]                      instruction,
  output logic [31:0]                      PCplus4,
  output logic                             IF_ID_Write
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_pc_inflight;
  logic [31:0]  w_pc_inflight_next;

  logic         w_buf_valid;
  logic [31:0]  w_buf_instr;
  logic [31:0]  w_buf_pc4;
  logic         w_if_id_write;
  logic         w_imem_req;
  logic         w_accept;
  logic         w_load;

  // A word leaves the buffer only when nothing holds the IF/ID stage.
  assign w_if_id_write = w_buf_valid & ~stall & ~redirect;

  // A new request may issue only if the buffer will have room for its word:
  // either it is empty or it is being emptied this very edge.
  assign w_imem_req = (r_state == S_REQ) & (~w_buf_valid | w_if_id_write);
  assign w_accept   = w_imem_req & imem.imem_ready;

  // -------------------------------------------------------------------------
  // State / PC registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_pc          <= word_align(RESET_PC);
      r_pc_inflight <= word_align(RESET_PC);
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_pc_inflight <= w_pc_inflight_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Redirect overrides every state action.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_pc_inflight_next = r_pc_inflight;
    w_load             = 1'b0;

    if (redirect) begin
      w_pc_next = word_align(redirect_pc);
      if (r_state != S_REQ) begin
        // A response is still owed; if it is not arriving now it must be
        // swallowed later. If it arrives now it is simply not loaded.
        w_state_next = imem.imem_rvalid ? S_REQ : S_DROP;
      end else begin
        // A request accepted this edge cannot be answered before the next
        // cycle, so its word is always stale.
        w_state_next = w_accept ? S_DROP : S_REQ;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            w_pc_inflight_next = r_pc;
            w_pc_next          = r_pc + PC_INC;
            w_state_next       = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            w_load       = 1'b1;
            w_state_next = S_REQ;
          end
        end
        S_DROP: begin
          if (imem.imem_rvalid) begin
            w_state_next = S_REQ;
          end
        end
        default: begin
          w_state_next = S_REQ;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Holding buffer
  // -------------------------------------------------------------------------
  fetch_holding_buffer u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_instr   (imem.imem_rdata),
    .i_pc4     (r_pc_inflight + PC_INC),
    .i_consume (w_if_id_write),
    .i_flush   (redirect),
    .o_valid   (w_buf_valid),
    .o_instr   (w_buf_instr),
    .o_pc4     (w_buf_pc4)
  );

  assign imem.imem_req  = w_imem_req;
  assign imem.imem_addr = r_pc;
  assign instruction    = w_buf_instr;
  assign PCplus4        = w_buf_pc4;
  assign IF_ID_Write    = w_if_id_write;

  // Memory must never answer when no request is outstanding.
  a_no_rvalid_in_req : assert property (
    @(posedge clk) disable iff (reset) !(imem.imem_rvalid && (r_state == S_REQ))
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] PCplus4;
  logic        IF_ID_Write;

  int n_checks = 0;
  int n_fail   = 0;

  instruction_fetch_unit_if imem_bus ();

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .instruction (instruction),
    .PCplus4     (PCplus4),
    .IF_ID_Write (IF_ID_Write)
  );

  always #5 clk = ~clk;

  // Instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h2009_0005;
    if (addr == 32'h4) return 32'h0109_5020;
    return {~addr[15:0], addr[15:0]} ^ 32'h1234_0000;
  endfunction

  // Memory model: fixed latency, one outstanding read, shares the reset
  int          mem_lat = 1;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_paddr;

  always @(posedge clk) begin
    if (reset) begin
      mem_pend             <= 1'b0;
      mem_cnt              <= 0;
      imem_bus.imem_rvalid <= 1'b0;
      imem_bus.imem_rdata  <= 32'h0;
    end else begin
      imem_bus.imem_rvalid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_bus.imem_rvalid <= 1'b1;
          imem_bus.imem_rdata  <= mem_word(mem_paddr);
          mem_pend             <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (imem_bus.imem_req && imem_bus.imem_ready) begin
        if (mem_lat <= 1) begin
          imem_bus.imem_rvalid <= 1'b1;
          imem_bus.imem_rdata  <= mem_word(imem_bus.imem_addr);
        end else begin
          mem_pend  <= 1'b1;
          mem_cnt   <= mem_lat - 1;
          mem_paddr <= imem_bus.imem_addr;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  // Advance until IF/ID captures a word (or the cycle budget expires)
  task automatic wait_write(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (IF_ID_Write === 1'b1) begin
        ok = 1'b1;
        $display("fetch: PCplus4=%h instruction=%h", PCplus4, instruction);
        break;
      end
      step();
    end
  endtask

  task automatic wait_req(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (imem_bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok;
    mem_lat = 1; imem_bus.imem_ready = 1'b0;
    apply_reset();
    n_checks++; if (imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL reset_req got=%b exp=1", imem_bus.imem_req); end
    n_checks++; if (imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=00000000", imem_bus.imem_addr); end
    n_checks++; if (instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=00000000", instruction); end
    n_checks++; if (PCplus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got=%h exp=00000000", PCplus4); end
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", IF_ID_Write); end
    // Memory not ready: request must be held
    step(); step();
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL hold_req got=%b/%h exp=1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL hold_write got=%b exp=0", IF_ID_Write); end
    imem_bus.imem_ready = 1'b1;
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_write timeout got=%b exp=1", ok); end
    n_checks++; if (instruction !== 32'h2009_0005) begin n_fail++; $display("FAIL first_instr got=%h exp=20090005", instruction); end
    n_checks++; if (PCplus4 !== 32'h4) begin n_fail++; $display("FAIL first_pc4 got=%h exp=00000004", PCplus4); end
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL next_req got=%b/%h exp=1/00000004", imem_bus.imem_req, imem_bus.imem_addr); end
    step();
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL pulse_len got=%b exp=0", IF_ID_Write); end
  endtask

  task automatic test_stall();
    bit ok;
    mem_lat = 1; imem_bus.imem_ready = 1'b1;
    apply_reset();
    wait_write(10, ok);
    step();                       // word 0 taken, request for 0x4 accepted
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL stall_write[%0d] got=%b exp=0", i, IF_ID_Write); end
      n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_bus.imem_req); end
      n_checks++; if (instruction !== 32'h0109_5020 || PCplus4 !== 32'h8) begin n_fail++; $display("FAIL stall_hold[%0d] got=%h/%h exp=01095020/00000008", i, instruction, PCplus4); end
    end
    stall = 1'b0;
    #1;
    $display("release: PCplus4=%h instruction=%h write=%b", PCplus4, instruction, IF_ID_Write);
    n_checks++; if (IF_ID_Write !== 1'b1) begin n_fail++; $display("FAIL release_write got=%b exp=1", IF_ID_Write); end
    n_checks++; if (instruction !== 32'h0109_5020 || PCplus4 !== 32'h8) begin n_fail++; $display("FAIL release_data got=%h/%h exp=01095020/00000008", instruction, PCplus4); end
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL release_req got=%b/%h exp=1/00000008", imem_bus.imem_req, imem_bus.imem_addr); end
    step();
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL release_pulse got=%b exp=0", IF_ID_Write); end
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'hC || instruction !== mem_word(32'h8)) begin n_fail++; $display("FAIL after_stall got=%b/%h/%h exp=1/0000000c/%h", ok, PCplus4, instruction, mem_word(32'h8)); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    mem_lat = 3; imem_bus.imem_ready = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      wait_write(20, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rw_write[%0d] timeout got=%b exp=1", k, ok); end
      if (k < 2) step();
    end
    n_checks++; if (PCplus4 !== 32'hC || imem_bus.imem_addr !== 32'hC || imem_bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_setup got=%h/%h/%b exp=0000000c/0000000c/1", PCplus4, imem_bus.imem_addr, imem_bus.imem_req); end
    step();                       // request for 0xC now in S_WAIT
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL rw_write_redirect got=%b exp=0", IF_ID_Write); end
    step();
    redirect = 1'b0;
    #1;
    n_checks++; if (imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_drop_req got=%b exp=0", imem_bus.imem_req); end
    wait_req(20, ok);
    n_checks++; if (ok !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL rw_target got=%b/%h exp=1/00000040", ok, imem_bus.imem_addr); end
    wait_write(20, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h44 || instruction !== mem_word(32'h40)) begin n_fail++; $display("FAIL rw_first got=%b/%h/%h exp=1/00000044/%h", ok, PCplus4, instruction, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_stall();
    bit ok;
    mem_lat = 1; imem_bus.imem_ready = 1'b1;
    apply_reset();
    wait_write(10, ok);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    n_checks++; if (IF_ID_Write !== 1'b0 || imem_bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_same got=%b/%b exp=0/0", IF_ID_Write, imem_bus.imem_req); end
    step();
    stall = 1'b0; redirect = 1'b0;
    #1;
    n_checks++; if (IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL rs_flushed got=%b exp=0", IF_ID_Write); end
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL rs_req got=%b/%h exp=1/00000100", imem_bus.imem_req, imem_bus.imem_addr); end
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h104 || instruction !== mem_word(32'h100)) begin n_fail++; $display("FAIL rs_first got=%b/%h/%h exp=1/00000104/%h", ok, PCplus4, instruction, mem_word(32'h100)); end
  endtask

  task automatic test_align_wrap();
    bit ok;
    mem_lat = 1; imem_bus.imem_ready = 1'b1;
    apply_reset();
    redirect = 1'b1; redirect_pc = 32'h0000_0042;
    #1;
    step();                       // request for 0x0 accepted with redirect -> dropped
    redirect = 1'b0;
    #1;
    wait_req(10, ok);
    n_checks++; if (ok !== 1'b1 || imem_bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL align_addr got=%b/%h exp=1/00000040", ok, imem_bus.imem_addr); end
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h44) begin n_fail++; $display("FAIL align_pc4 got=%b/%h exp=1/00000044", ok, PCplus4); end
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    step();
    redirect = 1'b0;
    #1;
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h0 || instruction !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_pc4 got=%b/%h/%h exp=1/00000000/%h", ok, PCplus4, instruction, mem_word(32'hFFFF_FFFC)); end
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got=%b/%h exp=1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    step();
    wait_write(10, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h4 || instruction !== 32'h2009_0005) begin n_fail++; $display("FAIL wrap_after got=%b/%h/%h exp=1/00000004/20090005", ok, PCplus4, instruction); end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    mem_lat = 3; imem_bus.imem_ready = 1'b1;
    apply_reset();
    wait_write(20, ok);
    step();                       // request for 0x4 accepted
    step();                       // still waiting
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_req got=%b/%h exp=1/00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    n_checks++; if (instruction !== 32'h0 || PCplus4 !== 32'h0 || IF_ID_Write !== 1'b0) begin n_fail++; $display("FAIL mid_out got=%h/%h/%b exp=00000000/00000000/0", instruction, PCplus4, IF_ID_Write); end
    wait_write(20, ok);
    n_checks++; if (ok !== 1'b1 || PCplus4 !== 32'h4 || instruction !== 32'h2009_0005) begin n_fail++; $display("FAIL mid_refetch got=%b/%h/%h exp=1/00000004/20090005", ok, PCplus4, instruction); end
  endtask

  task automatic test_back_to_back();
    int          writes;
    logic [31:0] last_pc4;
    mem_lat = 1; imem_bus.imem_ready = 1'b1;
    apply_reset();
    writes = 0; last_pc4 = 32'h0;
    for (int c = 1; c < 20; c++) begin
      step();
      if (IF_ID_Write === 1'b1) begin
        writes++;
        $display("fetch: PCplus4=%h instruction=%h", PCplus4, instruction);
        n_checks++; if (PCplus4 !== last_pc4 + 32'd4) begin n_fail++; $display("FAIL b2b_seq got=%h exp=%h", PCplus4, last_pc4 + 32'd4); end
        n_checks++; if (instruction !== mem_word(last_pc4)) begin n_fail++; $display("FAIL b2b_instr got=%h exp=%h", instruction, mem_word(last_pc4)); end
        last_pc4 = last_pc4 + 32'd4;
      end
    end
    n_checks++; if (writes != 9) begin n_fail++; $display("FAIL b2b_rate got=%0d exp=9", writes); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_bus.imem_ready = 1'b0;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_align_wrap();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage front end. Owns the PC, issues single-outstanding word reads to instruction memory, and buffers the returned word. It presents instruction / PCplus4 / IF_ID_Write to the IF/ID pipeline register, which captures fields when IF_ID_Write=1 and loads a zero bubble when IF_ID_Write=0. It consumes stall from the hazard unit and branch/jump redirects from ID/EX.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: IF/ID must not accept a new instruction this cycle
redirect  input  1  taken branch/jump this cycle
redirect_pc  input  32  target PC; bits [1:0] ignored, treated as 0
imem_req  output  1  read request valid
imem_addr  output  32  word address, bits [1:0] always 0
imem_ready  input  1  memory accepts request when imem_req & imem_ready
imem_rvalid  input  1  read data valid, one pulse per accepted request, latency >=1 cycle
imem_rdata  input  32  instruction word
instruction  output  32  word to IF/ID
PCplus4  output  32  address of presented word + 4, to IF/ID
IF_ID_Write  output  1  1 = IF/ID captures instruction this edge; 0 = bubble

Behaviour:
- Registers: pc, pc_inflight, state, buf_valid, buf_instr, buf_pc4.
- Reset (clk edge with reset=1): pc=RESET_PC, state=S_REQ, buf_valid=0, buf_instr=0, buf_pc4=0. Outputs next cycle: imem_req=1, imem_addr=RESET_PC, instruction=0, PCplus4=0, IF_ID_Write=0. reset overrides all other inputs. rvalid from pre-reset requests is not tracked, because memory shares the reset.
- Combinational outputs: instruction=buf_instr; PCplus4=buf_pc4; IF_ID_Write=buf_valid & ~stall & ~redirect; imem_req=(state==S_REQ) & (~buf_valid | IF_ID_Write); imem_addr=pc.
- consume = IF_ID_Write. At the edge, buf_valid clears unless it is refilled in the same cycle.
- States:
  S_REQ: on imem_req & imem_ready, pc_inflight<=pc, pc<=pc+4, go S_WAIT.
  S_WAIT: on imem_rvalid, buf_instr<=imem_rdata, buf_pc4<=pc_inflight+4, buf_valid<=1, go S_REQ.
  S_DROP: on imem_rvalid, discard the data and go S_REQ.
- Redirect has priority over stall and over every state action:
  - pc<={redirect_pc[31:2],2'b00}; buf_valid<=0; IF_ID_Write=0 that cycle.
  - A request is outstanding if state is S_WAIT or S_DROP, or it is accepted this cycle. If one is outstanding and its rvalid is not in this cycle, go S_DROP. Otherwise go S_REQ.
  - Redirect together with rvalid in S_WAIT: discard the data, go S_REQ.
  - Redirect in S_DROP with no rvalid: stay in S_DROP, pc updated.
- Stall: the buffer holds its content and IF_ID_Write=0. No new request issues while buf_valid=1 and not consumed. At most one buffered plus one in-flight word. No data is ever lost or duplicated.
- imem_rvalid in S_REQ is ignored; protocol error, assertion only.
- Arithmetic: 32-bit, PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Peak throughput with 1-cycle memory, no stall: one IF_ID_Write pulse every 2 cycles.

Decomposition:
- Package if_pkg: state enum {S_REQ, S_WAIT, S_DROP}, PC_INC=32'd4, NOP_WORD=32'h0000_0000.
- One sub-module fits naturally: fetch_holding_buffer (buf_valid/buf_instr/buf_pc4 with load, consume and flush). The PC and FSM stay in the top.

Test Plan:
- Reset, RESET_PC=0, memory 1-cycle latency, imem[0]=0x2009_0005 -> imem_addr=0x0, then instruction=0x2009_0005, PCplus4=0x4, IF_ID_Write=1 for one cycle; next request address 0x4.
- stall=1 for 3 cycles while buffer holds 0x0109_5020 (PCplus4=0x8) -> IF_ID_Write=0 and no imem_req during the stall. On release, one pulse with 0x0109_5020 / 0x8, then fetch of 0x8.
- redirect=1, redirect_pc=0x40, while a request to 0xC is in S_WAIT -> the 0xC response is dropped; next imem_addr=0x40; first delivered PCplus4=0x44.
- redirect together with stall and buf_valid=1 -> IF_ID_Write=0, buffer flushed, fetch restarts at the target.
- redirect_pc=0x0000_0042 -> imem_addr=0x40. PC at 0xFFFF_FFFC -> PCplus4=0x0, and the next imem_addr is 0x0.
- reset asserted mid S_WAIT with memory latency 3 -> all outputs return to reset values next cycle; refetch starts at RESET_PC.
